clock_ratio_detector: RTL and testbench

//   Measures a slow clock derived from reference_clk and reports its period in reference_clk cycles.
//   It also reports high/low phase lengths, a duty-balance check and a lock indication.

---
 rtl/clock_ratio_detector.sv | 233 +++++++++++++++++++++++
 tb/tb_clock_ratio_detector.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_ratio_detector.sv
// Measures the period and high/low phase lengths of a slow clock sampled on reference_clk,
// and reports duty balance, lock and stall status.
module clock_ratio_detector #(
    parameter int unsigned CNT_W       = 6,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_COUNT  = 3
) (
    input  logic             reference_clk,
    input  logic             reset,
    input  logic             measure_enable,
    input  logic             measured_clk,
    output logic [CNT_W-1:0] measured_ratio,
    output logic [CNT_W-1:0] high_cycles,
    output logic [CNT_W-1:0] low_cycles,
    output logic             ratio_valid,
    output logic             duty_ok,
    output logic             locked,
    output logic             stall
);

    localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntNearMax = CntMax - 1'b1;
    localparam logic [3:0]       LockTarget = 4'(LOCK_COUNT);

    typedef enum logic [2:0] {
        StIdle,
        StAcquire,
        StMeasure,
        StLocked,
        StStall
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CntMax) ? v : v + 1'b1;
    endfunction

    // Input synchronizer and edge detection
    logic s;
    logic s_prev_q;
    logic rise;

    if (SYNC_STAGES == 0) begin : g_no_sync
        assign s = measured_clk;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;
        always_ff @(posedge reference_clk or negedge reset) begin
            if (!reset) begin
                sync_q <= '0;
            end else begin
                sync_q[0] <= measured_clk;
                for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end
        assign s = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge reference_clk or negedge reset) begin
        if (!reset) begin
            s_prev_q <= 1'b0;
        end else begin
            s_prev_q <= s;
        end
    end

    assign rise = s & ~s_prev_q;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
    logic [CNT_W-1:0] prev_period_q, prev_period_d;
    logic             have_prev_q, have_prev_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0] measured_ratio_q, measured_ratio_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic             ratio_valid_q, ratio_valid_d;
    logic             duty_ok_q, duty_ok_d;
    logic             locked_q, locked_d;
    logic             stall_q, stall_d;

    // Run length of identical periods; a differing period starts a new run of one.
    logic             period_match;
    logic [3:0]       match_next;
    logic [CNT_W-1:0] phase_diff;

    assign period_match = have_prev_q && (period_cnt_q == prev_period_q);
    assign match_next   = !period_match        ? 4'd1 :
                          (match_cnt_q == 4'hF) ? 4'hF : match_cnt_q + 4'd1;
    assign phase_diff   = (high_cnt_q >= low_cnt_q) ? high_cnt_q - low_cnt_q
                                                    : low_cnt_q - high_cnt_q;

    always_comb begin
        state_d          = state_q;
        period_cnt_d     = period_cnt_q;
        high_cnt_d       = high_cnt_q;
        low_cnt_d        = low_cnt_q;
        prev_period_d    = prev_period_q;
        have_prev_d      = have_prev_q;
        match_cnt_d      = match_cnt_q;
        measured_ratio_d = measured_ratio_q;
        high_d           = high_q;
        low_d            = low_q;
        ratio_valid_d    = 1'b0;
        duty_ok_d        = duty_ok_q;
        locked_d         = locked_q;
        stall_d          = stall_q;

        if (!measure_enable) begin
            state_d          = StIdle;
            period_cnt_d     = '0;
            high_cnt_d       = '0;
            low_cnt_d        = '0;
            prev_period_d    = '0;
            have_prev_d      = 1'b0;
            match_cnt_d      = '0;
            measured_ratio_d = '0;
            high_d           = '0;
            low_d            = '0;
            duty_ok_d        = 1'b0;
            locked_d         = 1'b0;
            stall_d          = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StAcquire;
                end

                StAcquire, StStall: begin
                    if (rise) begin
                        // The rise cycle itself is the first high cycle of the period.
                        period_cnt_d = CNT_W'(1);
                        high_cnt_d   = CNT_W'(1);
                        low_cnt_d    = '0;
                        stall_d      = 1'b0;
                        state_d      = StMeasure;
                    end else if (state_q == StAcquire) begin
                        if (period_cnt_q >= CntNearMax) begin
                            period_cnt_d = CntMax;
                            stall_d      = 1'b1;
                            locked_d     = 1'b0;
                            state_d      = StStall;
                        end else begin
                            period_cnt_d = period_cnt_q + 1'b1;
                        end
                    end
                end

                StMeasure, StLocked: begin
                    if (rise) begin
                        measured_ratio_d = period_cnt_q;
                        high_d           = high_cnt_q;
                        low_d            = low_cnt_q;
                        ratio_valid_d    = 1'b1;
                        duty_ok_d        = (phase_diff <= CNT_W'(1));
                        prev_period_d    = period_cnt_q;
                        have_prev_d      = 1'b1;
                        match_cnt_d      = match_next;
                        locked_d         = (match_next >= LockTarget);
                        state_d          = (match_next >= LockTarget) ? StLocked : StMeasure;
                        period_cnt_d     = CNT_W'(1);
                        high_cnt_d       = CNT_W'(1);
                        low_cnt_d        = '0;
                    end else if (period_cnt_q >= CntNearMax) begin
                        // Next rise would give a period that cannot be represented.
                        period_cnt_d = CntMax;
                        stall_d      = 1'b1;
                        locked_d     = 1'b0;
                        have_prev_d  = 1'b0;
                        match_cnt_d  = '0;
                        state_d      = StStall;
                    end else begin
                        period_cnt_d = period_cnt_q + 1'b1;
                        if (s) begin
                            high_cnt_d = sat_inc(high_cnt_q);
                        end else begin
                            low_cnt_d = sat_inc(low_cnt_q);
                        end
                    end
                end

                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge reference_clk or negedge reset) begin
        if (!reset) begin
            state_q          <= StIdle;
            period_cnt_q     <= '0;
            high_cnt_q       <= '0;
            low_cnt_q        <= '0;
            prev_period_q    <= '0;
            have_prev_q      <= 1'b0;
            match_cnt_q      <= '0;
            measured_ratio_q <= '0;
            high_q           <= '0;
            low_q            <= '0;
            ratio_valid_q    <= 1'b0;
            duty_ok_q        <= 1'b0;
            locked_q         <= 1'b0;
            stall_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            period_cnt_q     <= period_cnt_d;
            high_cnt_q       <= high_cnt_d;
            low_cnt_q        <= low_cnt_d;
            prev_period_q    <= prev_period_d;
            have_prev_q      <= have_prev_d;
            match_cnt_q      <= match_cnt_d;
            measured_ratio_q <= measured_ratio_d;
            high_q           <= high_d;
            low_q            <= low_d;
            ratio_valid_q    <= ratio_valid_d;
            duty_ok_q        <= duty_ok_d;
            locked_q         <= locked_d;
            stall_q          <= stall_d;
        end
    end

    assign measured_ratio = measured_ratio_q;
    assign high_cycles    = high_q;
    assign low_cycles     = low_q;
    assign ratio_valid    = ratio_valid_q;
    assign duty_ok        = duty_ok_q;
    assign locked         = locked_q;
    assign stall          = stall_q;

endmodule

// File: tb/tb_clock_ratio_detector.sv
// Randomized and directed bench for clock_ratio_detector; expectations come from the rise times
// of the driven waveform.
module tb_clock_ratio_detector;

    localparam int CNT_W      = 6;
    localparam int LOCK_COUNT = 3;
    localparam int MAX_PERIOD = (1 << CNT_W) - 1;

    logic             reference_clk;
    logic             reset;
    logic             measure_enable;
    logic             measured_clk;
    logic [CNT_W-1:0] measured_ratio;
    logic [CNT_W-1:0] high_cycles;
    logic [CNT_W-1:0] low_cycles;
    logic             ratio_valid;
    logic             duty_ok;
    logic             locked;
    logic             stall;

    clock_ratio_detector #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(2),
        .LOCK_COUNT (LOCK_COUNT)
    ) dut (
        .reference_clk (reference_clk),
        .reset         (reset),
        .measure_enable(measure_enable),
        .measured_clk  (measured_clk),
        .measured_ratio(measured_ratio),
        .high_cycles   (high_cycles),
        .low_cycles    (low_cycles),
        .ratio_valid   (ratio_valid),
        .duty_ok       (duty_ok),
        .locked        (locked),
        .stall         (stall)
    );

    initial reference_clk = 1'b0;
    always #5 reference_clk = ~reference_clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_pulses = 0;

    task automatic check_value(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: one entry per period the detector must report, in order.
    typedef struct {
        int p;
        int h;
        int l;
        int lk;
    } exp_t;

    exp_t q[$];
    int   drv_cyc    = 0;
    int   prev_rise  = 0;
    bit   prev_valid = 1'b0;
    int   run        = 0;
    int   last_p     = 0;
    int   hi_acc     = 0;
    int   lo_acc     = 0;

    task automatic model_rise(input int t);
        int p;
        p = t - prev_rise;
        if (prev_valid && p < MAX_PERIOD) begin
            if (run > 0 && p == last_p) run++;
            else run = 1;
            last_p = p;
            q.push_back('{p: p, h: hi_acc, l: lo_acc, lk: (run >= LOCK_COUNT) ? 1 : 0});
        end else begin
            run = 0;
        end
        prev_rise  = t;
        prev_valid = 1'b1;
        hi_acc     = 0;
        lo_acc     = 0;
    endtask

    task automatic model_clear();
        prev_valid = 1'b0;
        run        = 0;
    endtask

    task automatic drive_cycle(input logic v);
        @(posedge reference_clk);
        #1;
        drv_cyc++;
        if (v && !measured_clk) model_rise(drv_cyc);
        if (v) hi_acc++;
        else lo_acc++;
        measured_clk = v;
    endtask

    task automatic drive_period(input int h, input int l, input int reps);
        for (int r = 0; r < reps; r++) begin
            repeat (h) drive_cycle(1'b1);
            repeat (l) drive_cycle(1'b0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_value(tag, int'(|{measured_ratio, high_cycles, low_cycles, ratio_valid, duty_ok,
                                locked, stall}), 0);
    endtask

    always @(negedge reference_clk) begin
        if (ratio_valid === 1'b1) begin
            exp_t e;
            n_pulses++;
            if (q.size() == 0) begin
                check_value("unexpected_valid", int'(measured_ratio), -1);
            end else begin
                e = q.pop_front();
                check_value("ratio", int'(measured_ratio), e.p);
                check_value("high", int'(high_cycles), e.h);
                check_value("low", int'(low_cycles), e.l);
                check_value("duty", int'(duty_ok), (e.h - e.l <= 1 && e.l - e.h <= 1) ? 1 : 0);
                check_value("locked", int'(locked), e.lk);
                check_value("stall_on_valid", int'(stall), 0);
            end
        end
    end

    initial begin
        int last_pulse_k;
        int stall_k;
        int pulses_before;

        reset          = 1'b0;
        measure_enable = 1'b0;
        measured_clk   = 1'b0;
        repeat (3) @(posedge reference_clk);
        @(negedge reference_clk);
        check_all_zero("reset_outputs");
        check_value("reset_stall", int'(stall), 0);
        reset = 1'b1;
        repeat (2) drive_cycle(1'b0);
        measure_enable = 1'b1;
        repeat (3) drive_cycle(1'b0);

        // Ratio 4, odd ratio 5 both orders, ratio 6 then 8, minimum ratio 2.
        drive_period(2, 2, 6);
        drive_period(2, 3, 5);
        drive_period(3, 2, 5);
        drive_period(3, 3, 5);
        drive_period(4, 4, 5);
        drive_period(1, 1, 5);
        // Longest reportable period, then one that is too long.
        drive_period(31, 31, 4);
        drive_period(31, 32, 3);
        drive_period(2, 2, 3);

        // Lock at 4, then hold low: stall 63 cycles after the last rise.
        drive_period(2, 2, 5);
        @(negedge reference_clk);
        check_value("locked_before_stall", int'(locked), 1);
        last_pulse_k = -1000;
        stall_k      = -1;
        for (int k = 1; k <= 100; k++) begin
            drive_cycle(k <= 2);
            @(negedge reference_clk);
            if (ratio_valid) last_pulse_k = k;
            if (stall && stall_k < 0) stall_k = k;
        end
        // The pulse lags its rise by one cycle, so 62 cycles pulse-to-stall.
        check_value("stall_delay", stall_k - last_pulse_k, MAX_PERIOD - 1);
        check_value("stall_set", int'(stall), 1);
        check_value("stall_locked", int'(locked), 0);
        check_value("stall_ratio_held", int'(measured_ratio), 4);
        drive_period(2, 2, 6);
        @(negedge reference_clk);
        check_value("stall_cleared", int'(stall), 0);
        check_value("relocked", int'(locked), 1);

        // Bypass: static input from enable, stall after 63 ACQUIRE cycles, no reports.
        repeat (3) drive_cycle(1'b0);
        measure_enable = 1'b0;
        model_clear();
        drive_cycle(1'b0);
        @(negedge reference_clk);
        check_all_zero("disable_outputs");
        repeat (2) drive_cycle(1'b0);
        measure_enable = 1'b1;
        pulses_before  = n_pulses;
        stall_k        = -1;
        for (int k = 1; k <= 80; k++) begin
            drive_cycle(1'b0);
            @(negedge reference_clk);
            if (stall && stall_k < 0) stall_k = k;
        end
        check_value("bypass_stall_at", stall_k, MAX_PERIOD + 1);
        check_value("bypass_no_valid", n_pulses - pulses_before, 0);

        // Reset mid-period while locked, then a fresh measurement.
        drive_period(3, 3, 5);
        drive_period(3, 2, 1);
        @(negedge reference_clk);
        check_value("locked_before_reset", int'(locked), 1);
        @(posedge reference_clk);
        #1;
        drv_cyc++;
        lo_acc++;
        reset = 1'b0;
        model_clear();
        #1;
        check_all_zero("async_reset_outputs");
        repeat (2) drive_cycle(1'b0);
        reset = 1'b1;
        drive_period(3, 4, 5);

        // Enable dropped mid-period while locked.
        drive_period(2, 2, 5);
        drive_period(2, 3, 1);
        @(negedge reference_clk);
        check_value("locked_before_disable", int'(locked), 1);
        measure_enable = 1'b0;
        model_clear();
        drive_cycle(1'b0);
        @(negedge reference_clk);
        check_all_zero("disable_mid_period");
        repeat (2) drive_cycle(1'b0);
        measure_enable = 1'b1;

        // Randomized periods and splits.
        for (int seg = 0; seg < 12; seg++) begin
            int n;
            int h;
            n = int'($urandom_range(2, 24));
            h = int'($urandom_range(1, n - 1));
            drive_period(h, n - h, int'($urandom_range(2, 6)));
        end

        repeat (10) drive_cycle(1'b0);
        check_value("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got %0d expected %0d", 0, 1);
        $fatal(1);
    end

endmodule
